cache_mem_ctrl: RTL and testbench

//  Backing-store controller directly downstream of cache_top; serves line refills (read bursts)
//  and dirty-line writebacks (write bursts) on the cache's memory-side port.

---
 rtl/cache_pkg.sv | 22 ++
 rtl/cache_mem_array.sv | 36 +++
 rtl/cache_mem_ctrl.sv | 174 +++++++++++++++++
 tb/tb_cache_mem_ctrl.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/cache_pkg.sv
// cache_pkg: line geometry and the backing-store FSM encoding shared by
// cache_top and cache_mem_ctrl.
package cache_pkg;

  localparam int DATA_W     = 32;
  localparam int LINE_WORDS = 4;
  localparam int OFF_BITS   = $clog2(LINE_WORDS) + 2;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_ACK    = 3'd1,
    S_WAIT   = 3'd2,
    S_RBURST = 3'd3,
    S_WBURST = 3'd4,
    S_DONE   = 3'd5
  } mem_state_e;

  function automatic mem_state_e burst_state(input logic we);
    return we ? S_WBURST : S_RBURST;
  endfunction

endpackage

// File: rtl/cache_mem_array.sv
// cache_mem_array: 1R/1W word array with a registered read port; contents are
// never reset, only the read register is.
module cache_mem_array #(
  parameter int DEPTH = 4096,
  parameter int WIDTH = 32,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [AW-1:0]    raddr_i,
  output logic [WIDTH-1:0] rdata_o,
  input  logic             we_i,
  input  logic [AW-1:0]    waddr_i,
  input  logic [WIDTH-1:0] wdata_i
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] rdata_q;

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rdata_q <= '0;
    end else begin
      rdata_q <= mem_q[raddr_i];
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/cache_mem_ctrl.sv
// cache_mem_ctrl: backing-store controller serving line refills and dirty-line
// writebacks for the cache behind a programmable access latency.
module cache_mem_ctrl
  import cache_pkg::*;
#(
  parameter int ADDR_W    = 32,
  parameter int MEM_WORDS = 4096,
  parameter int LATENCY   = 4
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              mem_req_i,
  input  logic              mem_we_i,
  input  logic [ADDR_W-1:0] mem_addr_i,
  output logic              mem_ack_o,
  input  logic              mem_wvalid_i,
  input  logic [DATA_W-1:0] mem_wdata_i,
  output logic              mem_wready_o,
  output logic              mem_rvalid_o,
  output logic [DATA_W-1:0] mem_rdata_o,
  output logic              mem_rlast_o,
  input  logic              mem_rready_i,
  output logic              mem_done_o,
  output logic              mem_busy_o
);

  localparam int BEAT_W = $clog2(LINE_WORDS);
  localparam int IDX_W  = $clog2(MEM_WORDS);
  localparam int TAG_W  = IDX_W - BEAT_W;
  localparam int LAT_W  = (LATENCY > 1) ? $clog2(LATENCY) : 1;

  localparam logic [BEAT_W-1:0] BEAT_LAST = BEAT_W'(LINE_WORDS - 1);
  localparam logic [LAT_W-1:0]  LAT_LAST  = LAT_W'((LATENCY > 0) ? (LATENCY - 1) : 0);

  mem_state_e        state_q, state_d;
  logic [TAG_W-1:0]  tag_q, tag_d;
  logic              we_q, we_d;
  logic [BEAT_W-1:0] beat_q, beat_d;
  logic [LAT_W-1:0]  lat_q, lat_d;

  logic ack_q, wready_q, rvalid_q, rlast_q, done_q, busy_q;

  logic              arr_we_s;
  logic [IDX_W-1:0]  arr_raddr_s;
  logic [IDX_W-1:0]  arr_waddr_s;
  logic [DATA_W-1:0] arr_rdata_s;
  logic              unused_addr_s;

  // Only the word-index bits of the line address select storage; the rest alias.
  assign unused_addr_s = ^{mem_addr_i[ADDR_W-1:IDX_W+2], mem_addr_i[OFF_BITS-1:0]};

  always_comb begin
    state_d  = state_q;
    tag_d    = tag_q;
    we_d     = we_q;
    beat_d   = beat_q;
    lat_d    = lat_q;
    arr_we_s = 1'b0;
    case (state_q)
      S_IDLE: begin
        beat_d = '0;
        lat_d  = '0;
        if (mem_req_i) begin
          tag_d   = mem_addr_i[IDX_W+1:OFF_BITS];
          we_d    = mem_we_i;
          state_d = S_ACK;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_ACK: begin
        if (LATENCY == 0) begin
          state_d = burst_state(we_q);
        end else begin
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        if (lat_q == LAT_LAST) begin
          lat_d   = '0;
          state_d = burst_state(we_q);
        end else begin
          lat_d = lat_q + LAT_W'(1);
        end
      end
      S_RBURST: begin
        if (mem_rready_i) begin
          beat_d = beat_q + BEAT_W'(1);
          if (beat_q == BEAT_LAST) begin
            state_d = S_IDLE;
          end else begin
            state_d = S_RBURST;
          end
        end else begin
          state_d = S_RBURST;
        end
      end
      S_WBURST: begin
        if (mem_wvalid_i) begin
          // A reset on the same edge must not commit the beat.
          arr_we_s = !rst_i;
          beat_d   = beat_q + BEAT_W'(1);
          if (beat_q == BEAT_LAST) begin
            state_d = S_DONE;
          end else begin
            state_d = S_WBURST;
          end
        end else begin
          state_d = S_WBURST;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= S_IDLE;
      tag_q    <= '0;
      we_q     <= 1'b0;
      beat_q   <= '0;
      lat_q    <= '0;
      ack_q    <= 1'b0;
      wready_q <= 1'b0;
      rvalid_q <= 1'b0;
      rlast_q  <= 1'b0;
      done_q   <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      tag_q    <= tag_d;
      we_q     <= we_d;
      beat_q   <= beat_d;
      lat_q    <= lat_d;
      ack_q    <= (state_d == S_ACK);
      wready_q <= (state_d == S_WBURST);
      rvalid_q <= (state_d == S_RBURST);
      rlast_q  <= (state_d == S_RBURST) && (beat_d == BEAT_LAST);
      done_q   <= (state_d == S_DONE);
      busy_q   <= (state_d != S_IDLE);
    end
  end

  // Reading the next-cycle index pre-fetches each beat so rdata lines up with rvalid.
  assign arr_raddr_s = {tag_d, beat_d};
  assign arr_waddr_s = {tag_q, beat_q};

  cache_mem_array #(
    .DEPTH (MEM_WORDS),
    .WIDTH (DATA_W)
  ) u_array (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .raddr_i (arr_raddr_s),
    .rdata_o (arr_rdata_s),
    .we_i    (arr_we_s),
    .waddr_i (arr_waddr_s),
    .wdata_i (mem_wdata_i)
  );

  assign mem_ack_o    = ack_q;
  assign mem_wready_o = wready_q;
  assign mem_rvalid_o = rvalid_q;
  assign mem_rdata_o  = rvalid_q ? arr_rdata_s : '0;
  assign mem_rlast_o  = rlast_q;
  assign mem_done_o   = done_q;
  assign mem_busy_o   = busy_q;

endmodule

// File: tb/tb_cache_mem_ctrl.sv
// tb_cache_mem_ctrl: randomized scoreboard bench for cache_mem_ctrl (LATENCY=4)
// plus a directed LATENCY=0 instance.
module tb_cache_mem_ctrl;

  localparam int LW  = 4;
  localparam int MW  = 4096;
  localparam int LAT = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst = 1'b1;
  logic        req = 1'b0, we = 1'b0, wvalid = 1'b0, rready = 1'b0;
  logic [31:0] addr = 32'h0, wdata = 32'h0;
  logic        ack, wready, rvalid, rlast, done, busy;
  logic [31:0] rdata;

  logic        z_req = 1'b0, z_we = 1'b0, z_wvalid = 1'b0, z_rready = 1'b0;
  logic [31:0] z_addr = 32'h0, z_wdata = 32'h0;
  logic        z_ack, z_wready, z_rvalid, z_rlast, z_done, z_busy;
  logic [31:0] z_rdata;

  cache_mem_ctrl #(.ADDR_W(32), .MEM_WORDS(MW), .LATENCY(LAT)) dut (
    .clk_i(clk), .rst_i(rst), .mem_req_i(req), .mem_we_i(we), .mem_addr_i(addr),
    .mem_ack_o(ack), .mem_wvalid_i(wvalid), .mem_wdata_i(wdata), .mem_wready_o(wready),
    .mem_rvalid_o(rvalid), .mem_rdata_o(rdata), .mem_rlast_o(rlast), .mem_rready_i(rready),
    .mem_done_o(done), .mem_busy_o(busy)
  );

  cache_mem_ctrl #(.ADDR_W(32), .MEM_WORDS(MW), .LATENCY(0)) dut0 (
    .clk_i(clk), .rst_i(rst), .mem_req_i(z_req), .mem_we_i(z_we), .mem_addr_i(z_addr),
    .mem_ack_o(z_ack), .mem_wvalid_i(z_wvalid), .mem_wdata_i(z_wdata), .mem_wready_o(z_wready),
    .mem_rvalid_o(z_rvalid), .mem_rdata_o(z_rdata), .mem_rlast_o(z_rlast), .mem_rready_i(z_rready),
    .mem_done_o(z_done), .mem_busy_o(z_busy)
  );

  int          n_checks = 0;
  int          n_fail   = 0;
  logic [31:0] model [MW];
  logic [32:0] exp_q [$];
  logic [31:0] wbuf [LW];
  bit          held_v = 1'b0;
  logic [32:0] held;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  // Word slot of beat k of the line containing byte address a.
  function automatic int unsigned widx(input logic [31:0] a, input int k);
    int unsigned line;
    line = (a / 4) / LW;
    return (line * LW + k) % MW;
  endfunction

  // Read-side monitor: pops the scoreboard on every accepted beat, checks stalls.
  initial forever begin
    @(negedge clk);
    if (!rst && rvalid) begin
      if (held_v) chk("rd_stable", {rlast, rdata}, held);
      if (rready) begin
        if (exp_q.size() == 0) chk("rd_unexpected_beat", 1, 0);
        else chk("rd_beat", {rlast, rdata}, exp_q.pop_front());
        held_v = 1'b0;
      end else begin
        held_v = 1'b1;
        held   = {rlast, rdata};
      end
    end else begin
      held_v = 1'b0;
    end
  end

  task automatic do_write(input logic [31:0] a, input bit gaps, input int abort_at);
    int cyc, n, target;
    bit hs;
    req = 1'b1; we = 1'b1; addr = a; rready = 1'($urandom_range(0, 1));
    cyc = 0;
    do begin step; cyc++; end while (!ack && cyc < 20);
    chk("wr_ack_latency", cyc, 1);
    req = 1'b0; we = 1'($urandom_range(0, 1)); addr = $urandom;
    cyc = 0;
    do begin
      step; cyc++;
      if (cyc == 1) chk("wr_ack_pulse", ack, 0);
    end while (!wready && cyc < 20);
    chk("wr_wready_latency", cyc, LAT + 1);
    n = 0; cyc = 0;
    target = (abort_at < LW) ? abort_at : LW;
    while (n < target && cyc < 100) begin
      wvalid = gaps ? 1'($urandom_range(0, 1)) : 1'b1;
      wdata  = wvalid ? wbuf[n] : $urandom;
      hs     = wvalid && wready;
      step; cyc++;
      if (hs) begin
        model[widx(a, n)] = wbuf[n];
        n++;
      end
    end
    wvalid = 1'b0; wdata = $urandom;
    chk("wr_beats", n, target);
    if (target < LW) begin
      rst = 1'b1;
      step;
      chk("rst_outputs", {ack, wready, rvalid, rlast, done, busy, rdata}, 38'h0);
      rst = 1'b0;
      step;
      chk("rst_idle", busy, 0);
    end else begin
      chk("wr_done_pulse", {done, wready}, 2'b10);
      step;
      chk("wr_done_clear", {done, busy}, 2'b00);
    end
  endtask

  // mode 0: rready always high; 1: stall beat 1 for 3 cycles; 2: random rready.
  task automatic do_read(input logic [31:0] a, input int mode);
    int cyc, bt, stall;
    bit hs;
    for (int k = 0; k < LW; k++) exp_q.push_back({(k == LW - 1), model[widx(a, k)]});
    req = 1'b1; we = 1'b0; addr = a;
    cyc = 0;
    do begin step; cyc++; end while (!ack && cyc < 20);
    chk("rd_ack_latency", cyc, 1);
    req = 1'b0; addr = $urandom;
    cyc = 0;
    do begin
      wvalid = 1'($urandom_range(0, 1)); wdata = $urandom;
      rready = 1'($urandom_range(0, 1));
      step; cyc++;
      if (cyc == 1) chk("rd_ack_pulse", ack, 0);
    end while (!rvalid && cyc < 20);
    chk("rd_rvalid_latency", cyc, LAT + 1);
    bt = 0; stall = 0; cyc = 0;
    while ((exp_q.size() != 0 || rvalid) && cyc < 200) begin
      case (mode)
        0: rready = 1'b1;
        1: begin
          rready = !(bt == 1 && stall < 3);
          if (!rready) stall++;
        end
        default: rready = 1'($urandom_range(0, 1));
      endcase
      hs = rvalid && rready;
      wvalid = 1'($urandom_range(0, 1)); wdata = $urandom;
      step; cyc++;
      if (hs) bt++;
    end
    wvalid = 1'b0; rready = 1'b0;
    chk("rd_beat_count", bt, LW);
    chk("rd_queue_empty", exp_q.size(), 0);
    chk("rd_idle", busy, 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] a, zd;
    for (int i = 0; i < MW; i++) model[i] = 32'h0;
    rst = 1'b1;
    repeat (3) step;
    chk("reset_outputs", {ack, wready, rvalid, rlast, done, busy, rdata}, 38'h0);
    chk("reset_outputs_lat0", {z_ack, z_wready, z_rvalid, z_rlast, z_done, z_busy, z_rdata}, 38'h0);
    rst = 1'b0;
    step;
    chk("idle_after_reset", busy, 0);

    do_read(32'h0000_0000, 0);
    for (int k = 0; k < LW; k++) wbuf[k] = 32'h1111_AAAA + k;
    do_write(32'h0000_2000, 1'b0, LW);
    do_read(32'h0000_2000, 0);
    do_read(32'h0000_2000, 1);
    do_read(32'h0000_200C, 2);
    do_read(32'h0001_2000, 2);
    for (int k = 0; k < LW; k++) wbuf[k] = 32'h5555_0000 + k;
    do_write(32'h0000_4000, 1'b1, LW);
    for (int k = 0; k < LW; k++) wbuf[k] = 32'h3333_CCCC + k;
    do_write(32'h0000_4000, 1'b0, 2);
    do_read(32'h0000_4000, 2);

    for (int t = 0; t < 40; t++) begin
      a = 32'h0000_3000 | (32'($urandom_range(0, 7)) << 4) | 32'($urandom_range(0, 15))
          | (32'($urandom_range(0, 3)) << 14);
      if ($urandom_range(0, 1) == 1) begin
        for (int k = 0; k < LW; k++) wbuf[k] = $urandom;
        do_write(a, 1'b1, LW);
      end else begin
        do_read(a, 2);
      end
      repeat ($urandom_range(0, 3)) step;
    end

    z_req = 1'b1; z_we = 1'b1; z_addr = 32'h0000_0100;
    step;
    chk("z_ack", z_ack, 1);
    z_req = 1'b0;
    step;
    chk("z_wready_first", z_wready, 1);
    z_wvalid = 1'b1;
    for (int k = 0; k < LW; k++) begin
      z_wdata = 32'h7777_0000 + 32'(k);
      chk("z_wready_consecutive", z_wready, 1);
      if (k == 1) begin z_req = 1'b1; z_we = 1'b0; end
      step;
      chk("z_req_ignored_busy", z_ack, 0);
    end
    z_wvalid = 1'b0;
    chk("z_done", z_done, 1);
    step;
    chk("z_idle_no_ack", {z_ack, z_busy}, 2'b00);
    step;
    chk("z_ack_after_idle", z_ack, 1);
    z_req = 1'b0; z_rready = 1'b1;
    step;
    for (int k = 0; k < LW; k++) begin
      zd = 32'h7777_0000 + 32'(k);
      chk("z_rbeat", {z_rvalid, z_rlast, z_rdata}, {1'b1, (k == LW - 1), zd});
      step;
    end
    chk("z_rvalid_drop", {z_rvalid, z_busy}, 2'b00);
    z_rready = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
